// File: rtl/scsi_io_arbiter.sv
// scsi_io_arbiter
// Shares the io controller's single SD block-transfer interface between two
// SCSI target instances. Requests are granted round-robin. Each grant adds
// that channel's LBA base offset, issues one block read or write, and steers
// the sector-buffer write strobe, the read-back data and the ack to the
// granted target. A request from an unmounted channel completes at once with
// a dummy ack.
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   mounted[1:0]          bit i set when channel i has an image attached
//   io_lba0/1             per-channel block address
//   io_rd0/1, io_wr0/1    per-channel level requests, held until ack
//   io_ack0/1             per-channel ack
//   buff_din0/1           per-channel sector data going to the SD side
//   buff_wr[1:0]          per-channel sector write strobe (read data)
//   sd_lba                offset block address to the io controller
//   sd_rd, sd_wr          block read / write request to the io controller
//   sd_ack                high while the io controller moves the block
//   sd_buff_wr            io controller write strobe into the target buffer
//   sd_buff_din           granted target's data to the io controller
//   timeout_err           sticky: a request was abandoned waiting for sd_ack
module scsi_io_arbiter #(
  parameter logic [31:0] BASE0   = 32'd0,
  parameter logic [31:0] BASE1   = 32'd0,
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  mounted,
  input  logic [31:0] io_lba0,
  input  logic        io_rd0,
  input  logic        io_wr0,
  output logic        io_ack0,
  input  logic [31:0] io_lba1,
  input  logic        io_rd1,
  input  logic        io_wr1,
  output logic        io_ack1,
  input  logic [7:0]  buff_din0,
  input  logic [7:0]  buff_din1,
  output logic [1:0]  buff_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic        sd_buff_wr,
  output logic [7:0]  sd_buff_din,
  output logic        timeout_err
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    XFER,
    SKIP,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic [31:0] lba_q, lba_d;
  logic [23:0] timer_q, timer_d;
  logic        sdRd_q, sdRd_d;
  logic        sdWr_q, sdWr_d;
  logic        err_q, err_d;

  logic        req0, req1;
  logic        pickCh;
  logic        pickRd;

  assign req0 = io_rd0 | io_wr0;
  assign req1 = io_rd1 | io_wr1;

  // State register. last_q resets to 1 so channel 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      lba_q   <= 32'd0;
      timer_q <= 24'd0;
      sdRd_q  <= 1'b0;
      sdWr_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      lba_q   <= lba_d;
      timer_q <= timer_d;
      sdRd_q  <= sdRd_d;
      sdWr_q  <= sdWr_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic. The grant, direction and offset address are captured
  // once in IDLE; requests are not looked at again until the next IDLE, so a
  // request that drops early still runs to completion.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    lba_d   = lba_q;
    timer_d = timer_q;
    sdRd_d  = sdRd_q;
    sdWr_d  = sdWr_q;
    err_d   = err_q;
    pickCh  = (req0 && req1) ? ~last_q : req1;
    pickRd  = pickCh ? io_rd1 : io_rd0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt_d   = pickCh;
          lba_d   = pickCh ? (io_lba1 + BASE1) : (io_lba0 + BASE0);
          timer_d = 24'd0;
          if (mounted[pickCh]) begin
            state_d = ISSUE;
            sdRd_d  = pickRd;
            sdWr_d  = ~pickRd;
          end else begin
            state_d = SKIP;
          end
        end
      end
      ISSUE: begin
        // An ack in the same cycle as the last timer tick still wins.
        if (sd_ack) begin
          sdRd_d  = 1'b0;
          sdWr_d  = 1'b0;
          state_d = XFER;
        end else if (timer_q == TIMEOUT - 24'd1) begin
          sdRd_d  = 1'b0;
          sdWr_d  = 1'b0;
          err_d   = 1'b1;
          state_d = SKIP;
        end else begin
          timer_d = timer_q + 24'd1;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          state_d = DONE;
        end
      end
      SKIP: begin
        state_d = DONE;
      end
      DONE: begin
        last_d  = gnt_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Data-path steering and acks. The ack is a straight pass-through of
  // sd_ack during XFER and a forced one-cycle pulse in SKIP; the non-granted
  // channel never sees an ack.
  always_comb begin
    io_ack0     = 1'b0;
    io_ack1     = 1'b0;
    buff_wr     = 2'b00;
    sd_buff_din = 8'd0;
    if (state_q == XFER) begin
      if (gnt_q) begin
        io_ack1     = sd_ack;
        buff_wr     = {sd_buff_wr, 1'b0};
        sd_buff_din = buff_din1;
      end else begin
        io_ack0     = sd_ack;
        buff_wr     = {1'b0, sd_buff_wr};
        sd_buff_din = buff_din0;
      end
    end else if (state_q == SKIP) begin
      io_ack0 = ~gnt_q;
      io_ack1 = gnt_q;
    end
  end

  assign sd_lba      = lba_q;
  assign sd_rd       = sdRd_q;
  assign sd_wr       = sdWr_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_scsi_io_arbiter.sv
// Testbench for scsi_io_arbiter. The bench plays the io controller and both
// targets. A small reference model (round-robin memory, offset arithmetic)
// predicts grants, addresses and data steering.
module tb_scsi_io_arbiter;

  localparam logic [31:0] B0 = 32'd0;
  localparam logic [31:0] B1 = 32'd41056;
  localparam logic [23:0] TO = 24'd16;

  logic        clk;
  logic        rst_n;
  logic [1:0]  mounted;
  logic [31:0] io_lba0, io_lba1;
  logic        io_rd0, io_wr0, io_ack0;
  logic        io_rd1, io_wr1, io_ack1;
  logic [7:0]  buff_din0, buff_din1;
  logic [1:0]  buff_wr;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, sd_ack, sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;
  // Channel served most recently; 1 after reset so channel 0 wins a tie.
  bit modelLast;

  scsi_io_arbiter #(.BASE0(B0), .BASE1(B1), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .mounted(mounted),
    .io_lba0(io_lba0), .io_rd0(io_rd0), .io_wr0(io_wr0), .io_ack0(io_ack0),
    .io_lba1(io_lba1), .io_rd1(io_rd1), .io_wr1(io_wr1), .io_ack1(io_ack1),
    .buff_din0(buff_din0), .buff_din1(buff_din1), .buff_wr(buff_wr),
    .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case a wait somehow never ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  task automatic dropAll();
    io_rd0 = 0; io_wr0 = 0; io_rd1 = 0; io_wr1 = 0;
    sd_ack = 0; sd_buff_wr = 0;
  endtask

  task automatic doReset();
    rst_n = 0;
    dropAll();
    mounted = 2'b11; io_lba0 = 0; io_lba1 = 0; buff_din0 = 0; buff_din1 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    modelLast = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    vectors++;
    if ({sd_rd, sd_wr, io_ack0, io_ack1, buff_wr, timeout_err} !== 7'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl got %b want 0000000",
               {sd_rd, sd_wr, io_ack0, io_ack1, buff_wr, timeout_err});
    end
    vectors++;
    if (sd_lba !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_lba got %0d want 0", sd_lba);
    end
    vectors++;
    if (sd_buff_din !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_din got %0h want 0", sd_buff_din);
    end
  endtask

  task automatic test_read_ch0();
    mounted = 2'b11; io_lba0 = 32'd100; io_rd0 = 1;
    @(negedge clk);
    vectors++;
    if ({sd_rd, sd_wr} !== 2'b10 || sd_lba !== 32'd100 + B0) begin
      miscompares++;
      $display("[TB] FAIL rd0_issue got rd/wr=%b lba=%0d want 10 lba=%0d",
               {sd_rd, sd_wr}, sd_lba, 32'd100 + B0);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (sd_rd !== 1'b1 || io_ack0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL rd0_hold got rd=%b ack0=%b want 1 0", sd_rd, io_ack0);
    end
    sd_ack = 1;
    @(negedge clk);
    vectors++;
    if (sd_rd !== 1'b0 || io_ack0 !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL rd0_ack got rd=%b ack0=%b want 0 1", sd_rd, io_ack0);
    end
    for (int i = 0; i < 6; i++) begin
      sd_buff_wr = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (buff_wr !== {1'b0, sd_buff_wr} || io_ack1 !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL rd0_strobe got buff_wr=%b ack1=%b want %b 0",
                 buff_wr, io_ack1, {1'b0, sd_buff_wr});
      end
      @(negedge clk);
    end
    io_rd0 = 0; sd_buff_wr = 0; sd_ack = 0;
    @(negedge clk);
    vectors++;
    if (io_ack0 !== 1'b0 || sd_lba !== 32'd100) begin
      miscompares++;
      $display("[TB] FAIL rd0_done got ack0=%b lba=%0d want 0 100", io_ack0, sd_lba);
    end
    @(negedge clk);
    modelLast = 1'b0;
  endtask

  task automatic test_write_ch1();
    io_lba1 = 32'd5; io_wr1 = 1;
    @(negedge clk);
    vectors++;
    if ({sd_rd, sd_wr} !== 2'b01 || sd_lba !== 32'd41061) begin
      miscompares++;
      $display("[TB] FAIL wr1_issue got rd/wr=%b lba=%0d want 01 lba=41061",
               {sd_rd, sd_wr}, sd_lba);
    end
    @(negedge clk);
    sd_ack = 1;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      buff_din0 = 8'($urandom); buff_din1 = 8'($urandom);
      sd_buff_wr = 1'($urandom_range(0, 1));
      #1;
      vectors++;
      if (sd_buff_din !== buff_din1 || {io_ack1, io_ack0} !== 2'b10 ||
          buff_wr !== {sd_buff_wr, 1'b0}) begin
        miscompares++;
        $display("[TB] FAIL wr1_data got din=%h acks=%b bw=%b want din=%h acks=10 bw=%b",
                 sd_buff_din, {io_ack1, io_ack0}, buff_wr, buff_din1, {sd_buff_wr, 1'b0});
      end
      @(negedge clk);
    end
    io_wr1 = 0; sd_buff_wr = 0; sd_ack = 0;
    @(negedge clk);
    @(negedge clk);
    modelLast = 1'b1;
  endtask

  task automatic test_unmounted();
    mounted = 2'b01; io_lba1 = 32'd7; io_rd1 = 1;
    @(negedge clk);
    vectors++;
    if ({sd_rd, sd_wr} !== 2'b00 || {io_ack1, io_ack0} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL unmnt_ack got rd/wr=%b acks=%b want 00 10",
               {sd_rd, sd_wr}, {io_ack1, io_ack0});
    end
    io_rd1 = 0;
    @(negedge clk);
    vectors++;
    if ({sd_rd, sd_wr, io_ack1, io_ack0} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL unmnt_pulse got %b want 0000", {sd_rd, sd_wr, io_ack1, io_ack0});
    end
    @(negedge clk);
    modelLast = 1'b1;
    mounted = 2'b11;
  endtask

  task automatic test_back_to_back();
    bit expCh;
    bit seen;
    doReset();
    mounted = 2'b00; io_lba0 = 32'h1000; io_lba1 = 32'h2000;
    io_rd0 = 1; io_rd1 = 1;
    for (int k = 0; k < 6; k++) begin
      expCh = ~modelLast;
      seen = 0;
      for (int w = 0; w < 5 && !seen; w++) begin
        @(negedge clk);
        seen = io_ack0 | io_ack1;
      end
      vectors++;
      if (!seen) begin
        miscompares++;
        $display("[TB] FAIL b2b_wait no ack within 5 cycles on grant %0d", k);
      end else if ({io_ack1, io_ack0} !== (expCh ? 2'b10 : 2'b01) ||
                   sd_lba !== (expCh ? io_lba1 + B1 : io_lba0 + B0)) begin
        miscompares++;
        $display("[TB] FAIL b2b_grant%0d got acks=%b lba=%h want ch%0d", k,
                 {io_ack1, io_ack0}, sd_lba, expCh);
      end
      modelLast = expCh;
      @(negedge clk);
    end
    dropAll();
    repeat (3) @(negedge clk);
    modelLast = 1'b1;
    mounted = 2'b11;
  endtask

  task automatic test_timeout();
    bit found = 0;
    int highCnt = 0;
    io_lba0 = 32'd33; io_rd0 = 1;
    for (int i = 0; i < 4 && !found; i++) begin
      @(negedge clk);
      found = sd_rd;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("[TB] FAIL to_rise sd_rd got 0 want 1 within 4 cycles");
    end
    while (sd_rd && highCnt < 40) begin
      highCnt++;
      @(negedge clk);
    end
    vectors++;
    if (highCnt !== 16) begin
      miscompares++;
      $display("[TB] FAIL to_len sd_rd high %0d cycles want 16", highCnt);
    end
    vectors++;
    if (io_ack0 !== 1'b1 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL to_skip got ack0=%b err=%b want 1 1", io_ack0, timeout_err);
    end
    io_rd0 = 0;
    @(negedge clk);
    vectors++;
    if (io_ack0 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL to_pulse ack0 got %b want 0", io_ack0);
    end
    @(negedge clk);
    modelLast = 1'b0;
    io_lba1 = 32'd9; io_wr1 = 1;
    @(negedge clk);
    vectors++;
    if ({sd_rd, sd_wr} !== 2'b01 || sd_lba !== 32'd9 + B1) begin
      miscompares++;
      $display("[TB] FAIL to_next got rd/wr=%b lba=%0d want 01 %0d",
               {sd_rd, sd_wr}, sd_lba, 32'd9 + B1);
    end
    sd_ack = 1;
    @(negedge clk);
    io_wr1 = 0; sd_ack = 0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (timeout_err !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL to_sticky err got %b want 1", timeout_err);
    end
    modelLast = 1'b1;
  endtask

  task automatic test_reset_mid();
    io_lba0 = 32'd77; io_rd0 = 1; buff_din0 = 8'hA5;
    @(negedge clk);
    sd_ack = 1;
    @(negedge clk);
    sd_buff_wr = 1;
    #1;
    vectors++;
    if (io_ack0 !== 1'b1 || buff_wr !== 2'b01 || sd_buff_din !== 8'hA5) begin
      miscompares++;
      $display("[TB] FAIL rm_pre got ack0=%b bw=%b din=%h want 1 01 a5",
               io_ack0, buff_wr, sd_buff_din);
    end
    #2;
    rst_n = 0;
    #1;
    vectors++;
    if ({sd_rd, sd_wr, io_ack0, io_ack1, buff_wr, timeout_err} !== 7'd0 ||
        sd_lba !== 32'd0 || sd_buff_din !== 8'd0) begin
      miscompares++;
      $display("[TB] FAIL rm_async got ctrl=%b lba=%0d din=%h want 0 0 0",
               {sd_rd, sd_wr, io_ack0, io_ack1, buff_wr, timeout_err}, sd_lba, sd_buff_din);
    end
    dropAll();
    @(negedge clk);
    rst_n = 1;
    modelLast = 1'b1;
    @(negedge clk);
    io_lba1 = 32'd3; io_wr1 = 1;
    @(negedge clk);
    vectors++;
    if ({sd_rd, sd_wr} !== 2'b01 || sd_lba !== 32'd3 + B1) begin
      miscompares++;
      $display("[TB] FAIL rm_after got rd/wr=%b lba=%0d want 01 %0d",
               {sd_rd, sd_wr}, sd_lba, 32'd3 + B1);
    end
    sd_ack = 1;
    @(negedge clk);
    vectors++;
    if ({io_ack1, io_ack0} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL rm_ack got %b want 10", {io_ack1, io_ack0});
    end
    io_wr1 = 0; sd_ack = 0;
    @(negedge clk);
    @(negedge clk);
    modelLast = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0]  r0, r1, mnt;
    logic [31:0] expLba;
    logic [1:0]  expAck, expBw;
    bit          expCh, expRd;
    for (int it = 0; it < 40; it++) begin
      r0 = 2'($urandom_range(0, 3));
      r1 = 2'($urandom_range(0, 3));
      if (r0 == 2'b00 && r1 == 2'b00) r0 = 2'b10;
      mnt = 2'($urandom_range(0, 3));
      io_lba0 = $urandom; io_lba1 = $urandom;
      mounted = mnt;
      {io_rd0, io_wr0} = r0;
      {io_rd1, io_wr1} = r1;
      // Reference: tie goes to the channel not served last; read beats write.
      if (r0 != 0 && r1 != 0) expCh = ~modelLast;
      else expCh = (r1 != 0);
      expRd  = expCh ? r1[1] : r0[1];
      expLba = expCh ? io_lba1 + B1 : io_lba0 + B0;
      expAck = expCh ? 2'b10 : 2'b01;
      @(negedge clk);
      vectors++;
      if (sd_lba !== expLba) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d_lba got %h want %h", it, sd_lba, expLba);
      end
      if (mnt[expCh]) begin
        vectors++;
        if ({sd_rd, sd_wr} !== {expRd, ~expRd}) begin
          miscompares++;
          $display("[TB] FAIL rnd%0d_dir got %b want %b", it, {sd_rd, sd_wr}, {expRd, ~expRd});
        end
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sd_ack = 1;
        @(negedge clk);
        for (int n = 0; n < int'($urandom_range(1, 4)); n++) begin
          sd_buff_wr = 1'($urandom_range(0, 1));
          buff_din0 = 8'($urandom); buff_din1 = 8'($urandom);
          expBw = expCh ? {sd_buff_wr, 1'b0} : {1'b0, sd_buff_wr};
          #1;
          vectors++;
          if ({io_ack1, io_ack0} !== expAck || buff_wr !== expBw ||
              sd_buff_din !== (expCh ? buff_din1 : buff_din0) || {sd_rd, sd_wr} !== 2'b00) begin
            miscompares++;
            $display("[TB] FAIL rnd%0d_xfer got acks=%b bw=%b din=%h want %b %b %h", it,
                     {io_ack1, io_ack0}, buff_wr, sd_buff_din, expAck, expBw,
                     expCh ? buff_din1 : buff_din0);
          end
          @(negedge clk);
        end
      end else begin
        vectors++;
        if ({sd_rd, sd_wr, io_ack1, io_ack0} !== {2'b00, expAck}) begin
          miscompares++;
          $display("[TB] FAIL rnd%0d_skip got %b want %b", it,
                   {sd_rd, sd_wr, io_ack1, io_ack0}, {2'b00, expAck});
        end
      end
      dropAll();
      @(negedge clk);
      vectors++;
      if ({io_ack1, io_ack0, sd_rd, sd_wr} !== 4'b0000 || sd_lba !== expLba) begin
        miscompares++;
        $display("[TB] FAIL rnd%0d_done got ctrl=%b lba=%h want 0000 %h", it,
                 {io_ack1, io_ack0, sd_rd, sd_wr}, sd_lba, expLba);
      end
      @(negedge clk);
      modelLast = expCh;
    end
  endtask

  initial begin
    test_reset();
    test_read_ch0();
    test_write_ch1();
    test_unmounted();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
